// File: rtl/mhsa_sched_pkg.sv
// Shared types, stage indices and helpers for the MHSA stage scheduler.
package mhsa_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_FINISH,
    ST_ERROR
  } sched_state_e;

  localparam int STG_LIN_Q   = 0;
  localparam int STG_LIN_K   = 1;
  localparam int STG_LIN_V   = 2;
  localparam int STG_QKMM    = 3;
  localparam int STG_SOFTMAX = 4;
  localparam int STG_SVMM    = 5;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_ADDR_W = 32;

  // Lowest set bit of mask at or above 'from'. Result is {found, index[4:0]};
  // masks up to 32 stages are supported.
  function automatic logic [5:0] next_set_bit(input logic [31:0] mask,
                                              input logic [5:0]  from);
    logic [5:0] res;
    res = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (6'(i) >= from)) res = {1'b1, 5'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mhsa_bar_mux.sv
// Combinational NUM_STAGES-to-1 selector for the shared memory bar ports.
// Outputs are forced to zero whenever valid is low.
module mhsa_bar_mux #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_BARS   = 3,
  parameter int WIDTH      = 64,
  parameter int ADDR_W     = 32,
  parameter int SEL_W      = 3
) (
  input  logic [SEL_W-1:0]                     sel,
  input  logic                                 valid,
  input  logic [NUM_STAGES*NUM_BARS-1:0]        st_we,
  input  logic [NUM_STAGES*NUM_BARS*ADDR_W-1:0] st_addr,
  input  logic [NUM_STAGES*NUM_BARS*WIDTH-1:0]  st_wdata,
  output logic [NUM_BARS-1:0]                   mem_we,
  output logic [NUM_BARS*ADDR_W-1:0]            mem_addr,
  output logic [NUM_BARS*WIDTH-1:0]             mem_wdata
);

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (valid && (sel == SEL_W'(s))) begin
        mem_we    = st_we[s*NUM_BARS +: NUM_BARS];
        mem_addr  = st_addr[s*NUM_BARS*ADDR_W +: NUM_BARS*ADDR_W];
        mem_wdata = st_wdata[s*NUM_BARS*WIDTH +: NUM_BARS*WIDTH];
      end
    end
  end

endmodule

// File: rtl/mhsa_stage_scheduler.sv
// Sequences the enabled MHSA stages in index order and routes the shared
// memory bars to the active stage. Optional watchdog: MHSA_SCHED_WATCHDOG_EN.
module mhsa_stage_scheduler
  import mhsa_sched_pkg::*;
#(
  parameter int NUM_STAGES     = 6,
  parameter int NUM_BARS       = 3,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = 'd200000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic [NUM_STAGES-1:0]                stage_en_i,
  output logic                                 done_o,
  output logic                                 busy_o,
  output logic                                 err_o,
  output logic [$clog2(NUM_STAGES)-1:0]        cur_stage_o,
  output logic [NUM_STAGES-1:0]                stage_start_o,
  input  logic [NUM_STAGES-1:0]                stage_done_i,
  input  logic [NUM_STAGES*NUM_BARS-1:0]        st_we_i,
  input  logic [NUM_STAGES*NUM_BARS*ADDR_W-1:0] st_addr_i,
  input  logic [NUM_STAGES*NUM_BARS*WIDTH-1:0]  st_wdata_i,
  output logic [NUM_BARS-1:0]                   mem_we_o,
  output logic [NUM_BARS*ADDR_W-1:0]            mem_addr_o,
  output logic [NUM_BARS*WIDTH-1:0]             mem_wdata_o
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  sched_state_e          state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] en_q;
  logic                  err_q;

  logic [31:0]           search_mask;
  logic [5:0]            search_from;
  logic [5:0]            nb;
  logic [NUM_STAGES-1:0] nb_onehot;
  logic                  wd_expired;

  // In IDLE the search runs over the incoming mask; afterwards over en_q above idx.
  always_comb begin
    search_mask = '0;
    search_from = '0;
    if (state == ST_IDLE) begin
      search_mask[NUM_STAGES-1:0] = stage_en_i;
    end else begin
      search_mask[NUM_STAGES-1:0] = en_q;
      search_from = 6'(idx) + 6'd1;
    end
  end

  assign nb        = next_set_bit(search_mask, search_from);
  assign nb_onehot = NUM_STAGES'(1) << nb[4:0];

`ifdef MHSA_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_cnt <= '0;
    else if (state != ST_RUN)  wd_cnt <= '0;
    else if (!wd_expired)      wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Stage handshake: stage_start_o[idx] is a level held until the stage
  // answers with a one-cycle stage_done_i[idx]; other done bits are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      en_q          <= '0;
      err_q         <= 1'b0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      stage_start_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            en_q   <= stage_en_i;
            err_q  <= 1'b0;
            busy_o <= 1'b1;
            if (nb[5]) begin
              state         <= ST_RUN;
              idx           <= IDX_W'(nb[4:0]);
              stage_start_o <= nb_onehot;
            end else begin
              state  <= ST_FINISH;
              done_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stage_done_i[idx]) begin
            state         <= ST_GAP;
            stage_start_o <= '0;
          end else if (wd_expired) begin
            state         <= ST_ERROR;
            stage_start_o <= '0;
            err_q         <= 1'b1;
          end
        end
        ST_GAP: begin
          if (nb[5]) begin
            state         <= ST_RUN;
            idx           <= IDX_W'(nb[4:0]);
            stage_start_o <= nb_onehot;
          end else begin
            state  <= ST_FINISH;
            done_o <= 1'b1;
          end
        end
        ST_ERROR: begin
          state  <= ST_FINISH;
          done_o <= 1'b1;
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign err_o       = err_q;
  assign cur_stage_o = idx;

  // The mux stays live through the done cycle, so a stage's final write lands.
  mhsa_bar_mux #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_BARS   (NUM_BARS),
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .SEL_W      (IDX_W)
  ) u_bar_mux (
    .sel       (idx),
    .valid     (state == ST_RUN),
    .st_we     (st_we_i),
    .st_addr   (st_addr_i),
    .st_wdata  (st_wdata_i),
    .mem_we    (mem_we_o),
    .mem_addr  (mem_addr_o),
    .mem_wdata (mem_wdata_o)
  );

endmodule
